// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Addresses are zero-extended to 64 bits so one helper serves every ADDR_W.
    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned offset_bits,
                                               input int unsigned index_w);
        logic [63:0] mask;
        mask = (64'd1 << index_w) - 64'd1;
        return (addr >> offset_bits) & mask;
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned offset_bits,
                                             input int unsigned index_w);
        return addr >> (offset_bits + index_w);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for SETS cache lines: one combinational read port, one write port.
module icache_line_array #(
    parameter int unsigned SETS    = 16,
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned TAG_W   = 25,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [INDEX_W-1:0] rd_index_i,
    output logic               rd_valid_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [DATA_W-1:0]  rd_data_o,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] wr_index_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               wr_set_valid_i,
    input  logic               clr_en_i,
    input  logic [INDEX_W-1:0] clr_index_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];

    // Valid bits: async clear on reset, per-line clear during flush, set on refill.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= {SETS{1'b0}};
        end else begin
            if (clr_en_i) begin
                valid_q[clr_index_i] <= 1'b0;
            end
            if (wr_en_i && wr_set_valid_i) begin
                valid_q[wr_index_i] <= 1'b1;
            end
        end
    end

    // Tag and data payload carry no reset; valid gates their use.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache with blocking refill FSM, sequential flush and hit/miss counters.
module instruction_cache_dm
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SETS        = 16,
    parameter int unsigned OFFSET_BITS = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              stall,
    input  logic              flush,
    output logic              flush_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned TAG_W   = ADDR_W - OFFSET_BITS - INDEX_W;

    state_e              state_q;
    logic [DATA_W-1:0]   instruction_q;
    logic                instr_valid_q;
    logic                flush_busy_q;
    logic                flush_pend_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [INDEX_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]    hit_cnt_q;
    logic [CNT_W-1:0]    miss_cnt_q;
    logic [CNT_W-1:0]    hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_d;

    logic [INDEX_W-1:0]  pc_index_s;
    logic [TAG_W-1:0]    pc_tag_s;
    logic [INDEX_W-1:0]  miss_index_s;
    logic [TAG_W-1:0]    miss_tag_s;
    logic                rd_valid_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic                hit_s;
    logic                refill_done_s;

    assign pc_index_s    = INDEX_W'(addr_index(64'(pc), OFFSET_BITS, INDEX_W));
    assign pc_tag_s      = TAG_W'(addr_tag(64'(pc), OFFSET_BITS, INDEX_W));
    assign miss_index_s  = INDEX_W'(addr_index(64'(mem_addr_q), OFFSET_BITS, INDEX_W));
    assign miss_tag_s    = TAG_W'(addr_tag(64'(mem_addr_q), OFFSET_BITS, INDEX_W));
    assign hit_s         = rd_valid_s && (rd_tag_s == pc_tag_s);
    assign refill_done_s = (state_q == ST_REFILL) && mem_ack;

    icache_line_array #(
        .SETS    (SETS),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clock          (clock),
        .reset_n        (reset_n),
        .rd_index_i     (pc_index_s),
        .rd_valid_o     (rd_valid_s),
        .rd_tag_o       (rd_tag_s),
        .rd_data_o      (rd_data_s),
        .wr_en_i        (refill_done_s),
        .wr_index_i     (miss_index_s),
        .wr_tag_i       (miss_tag_s),
        .wr_data_i      (mem_data),
        .wr_set_valid_i (1'b1),
        .clr_en_i       (state_q == ST_FLUSH),
        .clr_index_i    (flush_cnt_q)
    );

    // Saturating increments of both counters.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_cnt_q != {CNT_W{1'b1}}) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
        if (miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end else begin
            miss_cnt_d = miss_cnt_q;
        end
    end

    // Control FSM with registered outputs; flush takes priority over a same-cycle fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            instruction_q <= {DATA_W{1'b0}};
            instr_valid_q <= 1'b0;
            flush_busy_q  <= 1'b0;
            flush_pend_q  <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= {ADDR_W{1'b0}};
            flush_cnt_q   <= {INDEX_W{1'b0}};
            hit_cnt_q     <= {CNT_W{1'b0}};
            miss_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_q      <= ST_FLUSH;
                        flush_busy_q <= 1'b1;
                        flush_cnt_q  <= {INDEX_W{1'b0}};
                    end else if (fetch_en && hit_s) begin
                        instruction_q <= rd_data_s;
                        instr_valid_q <= 1'b1;
                        hit_cnt_q     <= hit_cnt_d;
                    end else if (fetch_en) begin
                        state_q    <= ST_REFILL;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {pc[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        miss_cnt_q <= miss_cnt_d;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack) begin
                        instruction_q <= mem_data;
                        instr_valid_q <= 1'b1;
                        mem_req_q     <= 1'b0;
                        flush_pend_q  <= 1'b0;
                        if (flush_pend_q || flush) begin
                            state_q      <= ST_FLUSH;
                            flush_busy_q <= 1'b1;
                            flush_cnt_q  <= {INDEX_W{1'b0}};
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == INDEX_W'(SETS - 1)) begin
                        flush_busy_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + INDEX_W'(1);
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    flush_busy_q <= 1'b0;
                    mem_req_q    <= 1'b0;
                end
            endcase
        end
    end

    assign stall       = (state_q != ST_IDLE) || flush_busy_q;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign flush_busy  = flush_busy_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

endmodule
